// File: rtl/conv_pkg.sv
// -----------------------------------------------------------------------------
// conv_pkg
// Shared definitions for the conv2 stage: pixel/window types, kernel geometry
// and the default conv2 input feature-map dimensions.
// -----------------------------------------------------------------------------
package conv_pkg;

    // 3x3 kernel geometry
    localparam int KERNEL_SIZE = 3;
    localparam int KERNEL_TAPS = KERNEL_SIZE * KERNEL_SIZE;

    // Default conv2 input map dimensions (pool1 output)
    localparam int CONV2_IMG_W = 13;
    localparam int CONV2_IMG_H = 13;

    // IEEE-754 single, carried as opaque bits
    typedef logic [31:0] float32_t;

    // One 3x3 window, index 0 = top-left, 8 = bottom-right
    typedef float32_t [0:KERNEL_TAPS-1] window_t;

endpackage : conv_pkg

// File: rtl/conv2_line_buffer.sv
// -----------------------------------------------------------------------------
// conv2_line_buffer
// DEPTH-entry, WIDTH-bit memory with read-before-write at a single address:
// rd_data shows the stored word at addr combinationally, and when wr_en is
// high the new word replaces it on the rising edge of clk.
// Contents are deliberately not reset; the consumer masks stale entries.
//
// Ports:
//   clk      clock
//   wr_en    write enable
//   addr     read/write address (0..DEPTH-1)
//   wr_data  word to store at addr
//   rd_data  word currently stored at addr (pre-write value)
// -----------------------------------------------------------------------------
module conv2_line_buffer #(
    parameter int DEPTH  = 13,
    parameter int WIDTH  = 64,
    parameter int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  wr_data,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem_r [0:DEPTH-1];

    // Asynchronous read gives the old word in the same cycle as the write.
    assign rd_data = mem_r[addr];

    // Storage write port; no reset so it maps onto plain memory.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[addr] <= wr_data;
        end
    end

endmodule : conv2_line_buffer

// File: rtl/conv2_window_gen.sv
// -----------------------------------------------------------------------------
// conv2_window_gen
// Turns a row-major pixel stream of one channel into every 3x3 window
// (stride 1, no padding) for the conv2 filter bank.
//
// Ports:
//   clk         clock
//   rst_n       asynchronous active-low reset
//   pix_valid   pix_data is valid this cycle (always accepted)
//   pix_data    current pixel
//   win_valid   one-cycle strobe: win_data holds a complete window
//   win_data    [0..2]=row r-2, [3..5]=row r-1, [6..8]=row r, left to right
//   win_row     output-map row of the window
//   win_col     output-map column of the window
//   frame_done  one-cycle strobe with the last window of a frame
// -----------------------------------------------------------------------------
module conv2_window_gen
    import conv_pkg::*;
#(
    parameter int IMG_W  = CONV2_IMG_W,
    parameter int IMG_H  = CONV2_IMG_H,
    parameter int DATA_W = 32,
    parameter int COL_W  = $clog2(IMG_W),
    parameter int ROW_W  = $clog2(IMG_H)
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                pix_valid,
    input  logic [DATA_W-1:0]                   pix_data,
    output logic                                win_valid,
    output logic [0:KERNEL_TAPS-1][DATA_W-1:0]  win_data,
    output logic [ROW_W-1:0]                    win_row,
    output logic [COL_W-1:0]                    win_col,
    output logic                                frame_done
);

    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_H - 1);
    localparam logic [COL_W-1:0] COL_FIRST = COL_W'(KERNEL_SIZE - 1);
    localparam logic [ROW_W-1:0] ROW_FIRST = ROW_W'(KERNEL_SIZE - 1);

    logic [COL_W-1:0]                   col_r;
    logic [ROW_W-1:0]                   row_r;
    logic [COL_W-1:0]                   col_next_s;
    logic [ROW_W-1:0]                   row_next_s;
    logic [0:KERNEL_TAPS-1][DATA_W-1:0] win_shift_r;
    logic [0:KERNEL_TAPS-1][DATA_W-1:0] win_next_s;
    logic [2*DATA_W-1:0]                lb_rd_s;
    logic [2*DATA_W-1:0]                lb_wr_s;
    logic [DATA_W-1:0]                  lb1_s;
    logic [DATA_W-1:0]                  lb2_s;
    logic                               fire_s;
    logic                               last_pix_s;

    // Both line buffers share one memory: upper half is lb2 (row r-2),
    // lower half is lb1 (row r-1). A write ages lb1 into lb2 and stores the
    // new pixel into lb1 at the same column.
    assign lb2_s   = lb_rd_s[2*DATA_W-1:DATA_W];
    assign lb1_s   = lb_rd_s[DATA_W-1:0];
    assign lb_wr_s = {lb1_s, pix_data};

    conv2_line_buffer #(
        .DEPTH  (IMG_W),
        .WIDTH  (2 * DATA_W),
        .ADDR_W (COL_W)
    ) u_line_buffer (
        .clk     (clk),
        .wr_en   (pix_valid),
        .addr    (col_r),
        .wr_data (lb_wr_s),
        .rd_data (lb_rd_s)
    );

    // Row/column counters advance per accepted pixel and wrap at frame end.
    always_comb begin
        col_next_s = col_r;
        row_next_s = row_r;
        if (pix_valid) begin
            if (col_r == COL_LAST) begin
                col_next_s = '0;
                if (row_r == ROW_LAST) begin
                    row_next_s = '0;
                end else begin
                    row_next_s = row_r + ROW_W'(1);
                end
            end else begin
                col_next_s = col_r + COL_W'(1);
                row_next_s = row_r;
            end
        end else begin
            col_next_s = col_r;
            row_next_s = row_r;
        end
    end

    // Window shift: every row moves left, new right column enters at 2/5/8.
    always_comb begin
        win_next_s    = win_shift_r;
        win_next_s[0] = win_shift_r[1];
        win_next_s[1] = win_shift_r[2];
        win_next_s[2] = lb2_s;
        win_next_s[3] = win_shift_r[4];
        win_next_s[4] = win_shift_r[5];
        win_next_s[5] = lb1_s;
        win_next_s[6] = win_shift_r[7];
        win_next_s[7] = win_shift_r[8];
        win_next_s[8] = pix_data;
    end

    // Rows 0/1 and columns 0/1 hold stale line-buffer or shift-register data,
    // so only pixels at row>=2 and col>=2 complete a real window.
    always_comb begin
        fire_s     = 1'b0;
        last_pix_s = 1'b0;
        if (pix_valid && (row_r >= ROW_FIRST) && (col_r >= COL_FIRST)) begin
            fire_s = 1'b1;
        end else begin
            fire_s = 1'b0;
        end
        if ((row_r == ROW_LAST) && (col_r == COL_LAST)) begin
            last_pix_s = 1'b1;
        end else begin
            last_pix_s = 1'b0;
        end
    end

    // Counter and shift-array state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_r       <= '0;
            row_r       <= '0;
            win_shift_r <= '0;
        end else if (pix_valid) begin
            col_r       <= col_next_s;
            row_r       <= row_next_s;
            win_shift_r <= win_next_s;
        end
    end

    // Registered outputs: window payload is captured only with its strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
            win_data   <= '0;
            win_row    <= '0;
            win_col    <= '0;
        end else begin
            win_valid  <= fire_s;
            frame_done <= fire_s & last_pix_s;
            if (fire_s) begin
                win_data <= win_next_s;
                win_row  <= row_r - ROW_FIRST;
                win_col  <= col_r - COL_FIRST;
            end
        end
    end

endmodule : conv2_window_gen

// File: tb/tb_conv2_window_gen.sv
// Directed bench for conv2_window_gen at the default 13x13 map size.
module tb_conv2_window_gen;

    localparam int W = 13;
    localparam int H = 13;
    localparam int NPIX = W * H;

    logic             clk;
    logic             rst_n;
    logic             pix_valid;
    logic [31:0]      pix_data;
    logic             win_valid;
    logic [0:8][31:0] win_data;
    logic [3:0]       win_row;
    logic [3:0]       win_col;
    logic             frame_done;

    int checks;
    int errors;

    conv2_window_gen dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pix_valid  (pix_valid),
        .pix_data   (pix_data),
        .win_valid  (win_valid),
        .win_data   (win_data),
        .win_row    (win_row),
        .win_col    (win_col),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one pixel for one edge; outputs are then sampled 1 time unit later.
    task automatic push(input logic [31:0] v);
        pix_valid = 1'b1;
        pix_data  = v;
        @(posedge clk);
        #1;
        pix_valid = 1'b0;
    endtask

    // Expected tap k of the window completed by pixel i of a frame valued base+i.
    function automatic logic [31:0] exp_word(input int base, input int i, input int k);
        int r;
        int c;
        r = i / W;
        c = i % W;
        return 32'(base + (r - 2 + k / 3) * W + (c - 2 + k % 3));
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        pix_valid = 1'b0;
        pix_data = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (win_valid !== 1'b0 || frame_done !== 1'b0 || win_data !== '0 ||
            win_row !== 4'd0 || win_col !== 4'd0) begin
            errors++;
            $display("FAIL reset_outputs valid=%b done=%b row=%0d col=%0d (need all 0)",
                     win_valid, frame_done, win_row, win_col);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Continuous frame valued i, plus a back-to-back frame valued 1000+i.
    task automatic test_frame(input int base, input bit gaps);
        int nwin;
        bit exp_v;
        int first_w[9];
        int wrap_w[9];
        int last_w[9];
        first_w = '{0, 1, 2, 13, 14, 15, 26, 27, 28};
        wrap_w  = '{13, 14, 15, 26, 27, 28, 39, 40, 41};
        last_w  = '{140, 141, 142, 153, 154, 155, 166, 167, 168};
        nwin = 0;
        for (int i = 0; i < NPIX; i++) begin
            if (gaps) begin
                int g;
                g = $urandom_range(5, 0);
                for (int j = 0; j < g; j++) begin
                    @(posedge clk);
                    #1;
                    checks++;
                    if (win_valid !== 1'b0 || frame_done !== 1'b0) begin
                        errors++;
                        $display("FAIL gap_strobe base %0d pix %0d valid=%b done=%b need 0",
                                 base, i, win_valid, frame_done);
                    end
                end
            end
            push(32'(base + i));
            exp_v = ((i / W) >= 2) && ((i % W) >= 2);
            checks++;
            if (win_valid !== exp_v) begin
                errors++;
                $display("FAIL win_valid base %0d pix %0d got %b need %b", base, i, win_valid, exp_v);
            end
            checks++;
            if (frame_done !== (i == NPIX - 1)) begin
                errors++;
                $display("FAIL frame_done base %0d pix %0d got %b need %b",
                         base, i, frame_done, (i == NPIX - 1));
            end
            if (win_valid === 1'b1) nwin++;
            if (exp_v) begin
                for (int k = 0; k < 9; k++) begin
                    checks++;
                    if (win_data[k] !== exp_word(base, i, k)) begin
                        errors++;
                        $display("FAIL win_data base %0d pix %0d tap %0d got %0d need %0d",
                                 base, i, k, win_data[k], exp_word(base, i, k));
                    end
                end
                checks++;
                if (win_row !== 4'((i / W) - 2) || win_col !== 4'((i % W) - 2)) begin
                    errors++;
                    $display("FAIL win_pos base %0d pix %0d got r%0d c%0d need r%0d c%0d",
                             base, i, win_row, win_col, (i / W) - 2, (i % W) - 2);
                end
            end
            // Hand-computed spot checks at first window, row wrap and frame end.
            if (i == 28 || i == 41 || i == 168) begin
                for (int k = 0; k < 9; k++) begin
                    int e;
                    e = (i == 28) ? first_w[k] : (i == 41) ? wrap_w[k] : last_w[k];
                    checks++;
                    if (win_data[k] !== 32'(base + e)) begin
                        errors++;
                        $display("FAIL spot_data base %0d pix %0d tap %0d got %0d need %0d",
                                 base, i, k, win_data[k], base + e);
                    end
                end
            end
        end
        checks++;
        if (nwin != 121) begin
            errors++;
            $display("FAIL window_count base %0d got %0d need 121", base, nwin);
        end
    endtask

    task automatic test_continuous();
        test_frame(0, 1'b0);
    endtask

    task automatic test_back_to_back();
        test_frame(1000, 1'b0);
    endtask

    task automatic test_idle_gaps();
        test_frame(0, 1'b1);
    endtask

    task automatic test_reset_mid_frame();
        int exp_w[9];
        exp_w = '{2000, 2001, 2002, 2013, 2014, 2015, 2026, 2027, 2028};
        for (int i = 0; i <= 50; i++) push(32'(500 + i));
        checks++;
        if (win_valid !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_strobe got %b need 1", win_valid);
        end
        rst_n = 1'b0;
        #2;
        checks++;
        if (win_valid !== 1'b0 || frame_done !== 1'b0 || win_data !== '0 ||
            win_row !== 4'd0 || win_col !== 4'd0) begin
            errors++;
            $display("FAIL mid_reset_outputs valid=%b row=%0d col=%0d tap0=%0d need all 0",
                     win_valid, win_row, win_col, win_data[0]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 29; i++) begin
            push(32'(2000 + i));
            checks++;
            if (win_valid !== (i == 28)) begin
                errors++;
                $display("FAIL restart_valid pix %0d got %b need %b", i, win_valid, (i == 28));
            end
        end
        for (int k = 0; k < 9; k++) begin
            checks++;
            if (win_data[k] !== 32'(exp_w[k])) begin
                errors++;
                $display("FAIL restart_data tap %0d got %0d need %0d", k, win_data[k], exp_w[k]);
            end
        end
        checks++;
        if (win_row !== 4'd0 || win_col !== 4'd0) begin
            errors++;
            $display("FAIL restart_pos got r%0d c%0d need r0 c0", win_row, win_col);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        pix_valid = 1'b0;
        pix_data = 32'd0;
        test_reset();
        test_continuous();
        test_back_to_back();
        test_idle_gaps();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_conv2_window_gen

// File: doc/conv2_window_gen.md
Name: conv2_window_gen

Overview:
- Producer side of the conv2 3x3 filter interface. Takes a row-major stream of float32 feature-map pixels for one channel and emits every 3x3 sliding window, stride 1, no padding.
- Each window is nine words plus a one-cycle valid, in the exact ordering the filter's data_out[0:8] / valid_in inputs expect.
- Sits between the conv1/pool output buffer and the bank of conv2 filters; one instance per input channel.

Parameters:
- IMG_W, 13, feature-map width in pixels (>=3).
- IMG_H, 13, feature-map height in pixels (>=3).
- DATA_W, 32, pixel width; IEEE-754 single, treated as opaque bits.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- pix_valid  in  1  pix_data valid this cycle; no backpressure, always accepted.
- pix_data  in  DATA_W  current pixel, row-major order.
- win_valid  out  1  one-cycle strobe; win_data holds a complete window.
- win_data  out  9 x DATA_W  window; [0..2]=row r-2, [3..5]=row r-1, [6..8]=row r; left to right within a row.
- win_row  out  $clog2(IMG_H)  output-map row of the window (r-2).
- win_col  out  $clog2(IMG_W)  output-map column of the window (c-2).
- frame_done  out  1  one-cycle strobe coincident with the last window of a frame.

Behaviour:
- Reset: col/row counters 0; win_valid 0; frame_done 0; win_data all 0; win_row/win_col 0; line buffers need not be cleared.
- Counters: col 0..IMG_W-1, advancing only on an accepted pixel. On wrap, col returns to 0 and row increments. On the last pixel (row IMG_H-1, col IMG_W-1) both return to 0, which starts a new frame.
- Storage: two line buffers of IMG_W words.
  - lb1 holds row r-1; lb2 holds row r-2.
  - On an accepted pixel at column c: read lb1[c] and lb2[c], write lb2[c] <= lb1[c] and lb1[c] <= pix_data.
- Window register is a 3x3 shift array. On an accepted pixel, each row shifts left by one. The new right column is {lb2[c], lb1[c], pix_data} into positions 2/5/8.
- Output condition: win_valid goes high in the cycle after acceptance of a pixel with row>=2 and col>=2. Latency is exactly 1 clk from the pix_valid edge.
  - Same edge: win_row=row-2, win_col=col-2.
  - frame_done=1 when that pixel is the frame's last pixel.
- Holding: when win_valid=0, win_data/win_row/win_col keep their last values; win_valid and frame_done are otherwise 0.
- Window count: exactly (IMG_H-2)*(IMG_W-2) windows per frame, 121 at the defaults.
- Idle gaps (pix_valid=0): all state holds and no strobe is issued. The gap length never changes the windows produced.
- Row wrap: columns 0 and 1 of every row never raise win_valid, so stale shift-register columns from the previous row are never exposed.
- Frame wrap: rows 0 and 1 of a new frame never raise win_valid, so stale line-buffer contents are masked. A back-to-back next frame needs no idle cycle.
- Reset mid-frame: everything returns to reset values at once. The next accepted pixel is treated as row 0, col 0.
- The block has no internal arithmetic; it is pure data movement and counting.

Decomposition:
- Shared package conv_pkg:
  - typedef float32_t (logic [31:0]).
  - typedef window_t (float32_t [0:8]).
  - localparam KERNEL_SIZE=3.
  - conv2 default map dimensions IMG_W/IMG_H.
- One sub-module, conv2_line_buffer: an IMG_W-deep, DATA_W-wide memory with read-before-write at an address in one cycle. Instantiated twice (lb1, lb2), or once at 2*DATA_W width.

Test Plan:
- Pixels i=0..168 with value 32'(i), pix_valid continuous:
  - first win_valid follows pixel 28, with win_data={0,1,2,13,14,15,26,27,28}, win_row=0, win_col=0;
  - exactly 121 strobes in the frame.
- Row wrap, same stream:
  - pixels 39 and 40 (row 3, col 0/1) produce no strobe;
  - pixel 41 gives {13,14,15,26,27,28,39,40,41}, row=1, col=0.
- End of frame: pixel 168 gives {140,141,142,153,154,155,166,167,168}, win_row=10, win_col=10, frame_done=1 on the same cycle; frame_done is 0 on every other cycle.
- Back-to-back second frame, values 1000+i:
  - no strobe before pixel 1028;
  - first window {1000,1001,1002,1013,1014,1015,1026,1027,1028}, containing no first-frame value.
- Random 0-5 idle cycles between pixels of frame 1: the window sequence is identical to the continuous run, and each strobe comes exactly 1 clk after its pixel.
- rst_n pulsed low after pixel 50 accepted:
  - outputs read 0 during reset;
  - restart with values 2000+i gives a first window of {2000,2001,2002,2013,2014,2015,2026,2027,2028} after 29 pixels.
